// File: rtl/operand_display_sequencer_pkg.sv
// Shared types and constants for the operand display sequencer.
package operand_display_pkg;

    // View codes double as the state encoding and the board LED value.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        A_HI = 3'd1,
        A_LO = 3'd2,
        B_HI = 3'd3,
        B_LO = 3'd4,
        R_HI = 3'd5,
        R_LO = 3'd6
    } view_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    // Advance order; IDLE is never a successor.
    function automatic view_t next_view(input view_t v);
        case (v)
            A_HI:    return A_LO;
            A_LO:    return B_HI;
            B_HI:    return B_LO;
            B_LO:    return R_HI;
            R_HI:    return R_LO;
            default: return A_HI;
        endcase
    endfunction

endpackage

// File: rtl/operand_display_sequencer_if.sv
// Operand/result inputs and display outputs of the sequencer.
interface operand_display_sequencer_if;
    logic        enable;
    logic        step;
    logic        auto_en;
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic [31:0] dataR;
    logic [2:0]  view;
    logic [6:0]  disp3;
    logic [6:0]  disp2;
    logic [6:0]  disp1;
    logic [6:0]  disp0;

    modport master (
        output enable, step, auto_en, dataA, dataB, dataR,
        input  view, disp3, disp2, disp1, disp0
    );

    modport slave (
        input  enable, step, auto_en, dataA, dataB, dataR,
        output view, disp3, disp2, disp1, disp0
    );
endinterface

// File: rtl/operand_display_sequencer_hex_to_7seg.sv
// Combinational hex nibble to active-low {g,f,e,d,c,b,a} segment decoder.
module hex_to_7seg (
    input  logic [3:0] i_hex,
    output logic [6:0] o_seg
);

    // Glyph lookup; lower-case b and d keep them distinct from 8 and 0.
    always_comb begin
        o_seg = 7'h7F;
        case (i_hex)
            4'h0: o_seg = 7'b1000000;
            4'h1: o_seg = 7'b1111001;
            4'h2: o_seg = 7'b0100100;
            4'h3: o_seg = 7'b0110000;
            4'h4: o_seg = 7'b0011001;
            4'h5: o_seg = 7'b0010010;
            4'h6: o_seg = 7'b0000010;
            4'h7: o_seg = 7'b1111000;
            4'h8: o_seg = 7'b0000000;
            4'h9: o_seg = 7'b0010000;
            4'hA: o_seg = 7'b0001000;
            4'hB: o_seg = 7'b0000011;
            4'hC: o_seg = 7'b1000110;
            4'hD: o_seg = 7'b0100001;
            4'hE: o_seg = 7'b0000110;
            4'hF: o_seg = 7'b0001110;
            default: o_seg = 7'h7F;
        endcase
    end

endmodule

// File: rtl/operand_display_sequencer.sv
// Cycles operands A/B (latched) and live result R across four 7-segment
// digits, 16 bits per view, advancing on a dwell timer or a step pulse.
module operand_display_sequencer
    import operand_display_pkg::*;
#(
    parameter int DWELL_CYCLES = 100_000_000,
    parameter int CNT_W        = 27
) (
    input  logic                        clk,
    input  logic                        reset,
    operand_display_sequencer_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_CYCLES - 1);

    view_t            r_state;
    view_t            w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [31:0]      r_latch_a;
    logic [31:0]      r_latch_b;
    logic             w_load;
    logic             w_advance;
    logic [15:0]      w_word;
    logic [6:0]       w_seg [4];
    logic [6:0]       r_disp3, r_disp2, r_disp1, r_disp0;

    // Step and timer expiry OR together so a coincidence is a single advance.
    assign w_advance = bus.step | (bus.auto_en & (r_cnt == CNT_LAST));

    // State register and dwell counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next state: losing enable beats advancing; counter resets on any move.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_load      = 1'b0;
        if (r_state == IDLE) begin
            w_cnt_nxt = '0;
            if (bus.enable) begin
                w_state_nxt = A_HI;
                w_load      = 1'b1;
            end
        end else if (!bus.enable) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
        end else if (w_advance) begin
            w_state_nxt = next_view(r_state);
            w_cnt_nxt   = '0;
        end else if (bus.auto_en) begin
            w_cnt_nxt = r_cnt + 1'b1;
        end
    end

    // Operands are captured once on entry so later edits do not disturb the view.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_latch_a <= '0;
            r_latch_b <= '0;
        end else if (w_load) begin
            r_latch_a <= bus.dataA;
            r_latch_b <= bus.dataB;
        end
    end

    // Select the 16-bit half for the current view; R is shown live.
    always_comb begin
        w_word = 16'h0000;
        case (r_state)
            A_HI:    w_word = r_latch_a[31:16];
            A_LO:    w_word = r_latch_a[15:0];
            B_HI:    w_word = r_latch_b[31:16];
            B_LO:    w_word = r_latch_b[15:0];
            R_HI:    w_word = bus.dataR[31:16];
            R_LO:    w_word = bus.dataR[15:0];
            default: w_word = 16'h0000;
        endcase
    end

    for (genvar g = 0; g < 4; g++) begin : g_hex
        hex_to_7seg u_hex (
            .i_hex (w_word[4*g +: 4]),
            .o_seg (w_seg[g])
        );
    end

    // Registered digit drive; IDLE shows dashes, reset blanks immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_disp3 <= SEG_BLANK;
            r_disp2 <= SEG_BLANK;
            r_disp1 <= SEG_BLANK;
            r_disp0 <= SEG_BLANK;
        end else if (r_state == IDLE) begin
            r_disp3 <= SEG_DASH;
            r_disp2 <= SEG_DASH;
            r_disp1 <= SEG_DASH;
            r_disp0 <= SEG_DASH;
        end else begin
            r_disp3 <= w_seg[3];
            r_disp2 <= w_seg[2];
            r_disp1 <= w_seg[1];
            r_disp0 <= w_seg[0];
        end
    end

    assign bus.view  = r_state;
    assign bus.disp3 = r_disp3;
    assign bus.disp2 = r_disp2;
    assign bus.disp1 = r_disp1;
    assign bus.disp0 = r_disp0;

endmodule

// File: tb/tb_operand_display_sequencer.sv
// Scoreboard bench: each entry carries the inputs for one cycle and the
// view/digits expected right after that cycle's clock edge.
module tb_operand_display_sequencer;

    localparam int DW = 4;
    localparam int CW = 3;

    localparam logic [27:0] DASH28  = {4{7'b0111111}};
    localparam logic [27:0] BLANK28 = {4{7'h7F}};

    typedef struct {
        string       name;
        bit          step;
        bit          auto_en;
        bit          en;
        logic [2:0]  v;
        logic [27:0] d;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    operand_display_sequencer_if bus ();

    operand_display_sequencer #(
        .DWELL_CYCLES (DW),
        .CNT_W        (CW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    wire [27:0] disp_all = {bus.disp3, bus.disp2, bus.disp1, bus.disp0};

    function automatic logic [6:0] seg(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;  default: return 7'b0001110;
        endcase
    endfunction

    function automatic logic [27:0] segw(input logic [15:0] w);
        return {seg(w[15:12]), seg(w[11:8]), seg(w[7:4]), seg(w[3:0])};
    endfunction

    // Word expected for a view with the common-setup operands.
    function automatic logic [15:0] setup_word(input int v);
        case (v)
            1: return 16'hAFAF;  2: return 16'h120F;  3: return 16'hFF0F;
            4: return 16'hAF12;  5: return 16'h1234;  default: return 16'h5678;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        reset = 1'b1;
        bus.enable = 1'b0; bus.step = 1'b0; bus.auto_en = 1'b0;
        bus.dataA = 32'hAFAF120F; bus.dataB = 32'hFF0FAF12; bus.dataR = 32'h12345678;
        tick(); tick();
        q.push_back('{"reset_hold", 1'b0, 1'b0, 1'b0, 3'd0, BLANK28});
        e = q.pop_front();
        tests++;
        if (bus.view !== e.v || disp_all !== e.d) begin
            fails++;
            $display("FAIL %s: got view=%0d disp=%h, want view=%0d disp=%h", e.name, bus.view, disp_all, e.v, e.d);
        end
        reset = 1'b0;
        q.push_back('{"idle_dash", 1'b0, 1'b0, 1'b0, 3'd0, DASH28});
        q.push_back('{"idle_hold", 1'b0, 1'b0, 1'b0, 3'd0, DASH28});
        while (q.size() != 0) begin
            e = q.pop_front();
            bus.step = e.step; bus.auto_en = e.auto_en; bus.enable = e.en;
            tick();
            tests++;
            if (bus.view !== e.v || disp_all !== e.d) begin
                fails++;
                $display("FAIL %s: got view=%0d disp=%h, want view=%0d disp=%h", e.name, bus.view, disp_all, e.v, e.d);
            end
        end
    endtask

    task automatic test_enable();
        exp_t e;
        q.push_back('{"enter_view", 1'b0, 1'b0, 1'b1, 3'd1, DASH28});
        q.push_back('{"enter_disp", 1'b0, 1'b0, 1'b1, 3'd1, segw(16'hAFAF)});
        for (int i = 0; i < 5; i++)
            q.push_back('{"manual_hold", 1'b0, 1'b0, 1'b1, 3'd1, segw(16'hAFAF)});
        while (q.size() != 0) begin
            e = q.pop_front();
            bus.step = e.step; bus.auto_en = e.auto_en; bus.enable = e.en;
            tick();
            tests++;
            if (bus.view !== e.v || disp_all !== e.d) begin
                fails++;
                $display("FAIL %s: got view=%0d disp=%h, want view=%0d disp=%h", e.name, bus.view, disp_all, e.v, e.d);
            end
        end
    endtask

    // Auto mode from A_HI with counter at 0: view moves on every 4th edge,
    // digits follow one edge later; runs a full wrap and on into A_LO.
    task automatic test_auto();
        exp_t e;
        for (int k = 1; k <= 28; k++) begin
            int v  = 1 + ((k / DW) % 6);
            int vp = 1 + (((k - 1) / DW) % 6);
            q.push_back('{"auto_cycle", 1'b0, 1'b1, 1'b1, 3'(v), segw(setup_word(vp))});
        end
        while (q.size() != 0) begin
            e = q.pop_front();
            bus.step = e.step; bus.auto_en = e.auto_en; bus.enable = e.en;
            tick();
            tests++;
            if (bus.view !== e.v || disp_all !== e.d) begin
                fails++;
                $display("FAIL %s: got view=%0d disp=%h, want view=%0d disp=%h", e.name, bus.view, disp_all, e.v, e.d);
            end
        end
    endtask

    // A is latched (edit ignored); R is live (edit shows one edge later).
    task automatic test_latch_live();
        exp_t e;
        bus.dataA = 32'h0;
        q.push_back('{"a_latched", 1'b0, 1'b0, 1'b1, 3'd2, segw(16'h120F)});
        q.push_back('{"step_b_hi", 1'b1, 1'b0, 1'b1, 3'd3, segw(16'h120F)});
        q.push_back('{"step_b_lo", 1'b1, 1'b0, 1'b1, 3'd4, segw(16'hFF0F)});
        q.push_back('{"step_r_hi", 1'b1, 1'b0, 1'b1, 3'd5, segw(16'hAF12)});
        q.push_back('{"step_r_lo", 1'b1, 1'b0, 1'b1, 3'd6, segw(16'h1234)});
        q.push_back('{"r_lo_disp", 1'b0, 1'b0, 1'b1, 3'd6, segw(16'h5678)});
        while (q.size() != 0) begin
            e = q.pop_front();
            bus.step = e.step; bus.auto_en = e.auto_en; bus.enable = e.en;
            tick();
            tests++;
            if (bus.view !== e.v || disp_all !== e.d) begin
                fails++;
                $display("FAIL %s: got view=%0d disp=%h, want view=%0d disp=%h", e.name, bus.view, disp_all, e.v, e.d);
            end
        end
        bus.dataR = 32'h0000ABCD;
        q.push_back('{"r_live", 1'b0, 1'b0, 1'b1, 3'd6, segw(16'hABCD)});
        while (q.size() != 0) begin
            e = q.pop_front();
            bus.step = e.step; bus.auto_en = e.auto_en; bus.enable = e.en;
            tick();
            tests++;
            if (bus.view !== e.v || disp_all !== e.d) begin
                fails++;
                $display("FAIL %s: got view=%0d disp=%h, want view=%0d disp=%h", e.name, bus.view, disp_all, e.v, e.d);
            end
        end
    endtask

    // Counter reaches 3, then step coincides with expiry: one advance, and
    // the next expiry comes a full 4 edges later.
    task automatic test_step_expiry();
        exp_t e;
        for (int i = 0; i < 3; i++)
            q.push_back('{"count_up", 1'b0, 1'b1, 1'b1, 3'd6, segw(16'hABCD)});
        q.push_back('{"step_and_expire", 1'b1, 1'b1, 1'b1, 3'd1, segw(16'hABCD)});
        for (int i = 0; i < 3; i++)
            q.push_back('{"counter_cleared", 1'b0, 1'b1, 1'b1, 3'd1, segw(16'hAFAF)});
        q.push_back('{"next_expire", 1'b0, 1'b1, 1'b1, 3'd2, segw(16'hAFAF)});
        while (q.size() != 0) begin
            e = q.pop_front();
            bus.step = e.step; bus.auto_en = e.auto_en; bus.enable = e.en;
            tick();
            tests++;
            if (bus.view !== e.v || disp_all !== e.d) begin
                fails++;
                $display("FAIL %s: got view=%0d disp=%h, want view=%0d disp=%h", e.name, bus.view, disp_all, e.v, e.d);
            end
        end
    endtask

    // Drop enable in B_HI, then confirm step/auto are inert in IDLE.
    task automatic test_enable_drop();
        exp_t e;
        q.push_back('{"step_b_hi", 1'b1, 1'b0, 1'b1, 3'd3, segw(16'h120F)});
        q.push_back('{"b_hi_disp", 1'b0, 1'b0, 1'b1, 3'd3, segw(16'hFF0F)});
        q.push_back('{"drop_view", 1'b0, 1'b0, 1'b0, 3'd0, segw(16'hFF0F)});
        q.push_back('{"drop_dash", 1'b0, 1'b0, 1'b0, 3'd0, DASH28});
        q.push_back('{"idle_step", 1'b1, 1'b0, 1'b0, 3'd0, DASH28});
        for (int i = 0; i < 5; i++)
            q.push_back('{"idle_auto", 1'b0, 1'b1, 1'b0, 3'd0, DASH28});
        while (q.size() != 0) begin
            e = q.pop_front();
            bus.step = e.step; bus.auto_en = e.auto_en; bus.enable = e.en;
            tick();
            tests++;
            if (bus.view !== e.v || disp_all !== e.d) begin
                fails++;
                $display("FAIL %s: got view=%0d disp=%h, want view=%0d disp=%h", e.name, bus.view, disp_all, e.v, e.d);
            end
        end
    endtask

    // Re-entry re-latches A (now 0); then reset mid-cycle in R_HI.
    task automatic test_async_reset();
        exp_t e;
        bus.dataR = 32'h12345678;
        q.push_back('{"reenter", 1'b0, 1'b0, 1'b1, 3'd1, DASH28});
        q.push_back('{"relatch_a", 1'b1, 1'b0, 1'b1, 3'd2, segw(16'h0000)});
        q.push_back('{"step_b_hi", 1'b1, 1'b0, 1'b1, 3'd3, segw(16'h0000)});
        q.push_back('{"step_b_lo", 1'b1, 1'b0, 1'b1, 3'd4, segw(16'hFF0F)});
        q.push_back('{"step_r_hi", 1'b1, 1'b0, 1'b1, 3'd5, segw(16'hAF12)});
        q.push_back('{"r_hi_disp", 1'b0, 1'b0, 1'b1, 3'd5, segw(16'h1234)});
        while (q.size() != 0) begin
            e = q.pop_front();
            bus.step = e.step; bus.auto_en = e.auto_en; bus.enable = e.en;
            tick();
            tests++;
            if (bus.view !== e.v || disp_all !== e.d) begin
                fails++;
                $display("FAIL %s: got view=%0d disp=%h, want view=%0d disp=%h", e.name, bus.view, disp_all, e.v, e.d);
            end
        end
        #2;
        reset = 1'b1;
        q.push_back('{"async_reset", 1'b0, 1'b0, 1'b1, 3'd0, BLANK28});
        #1;
        e = q.pop_front();
        tests++;
        if (bus.view !== e.v || disp_all !== e.d) begin
            fails++;
            $display("FAIL %s: got view=%0d disp=%h, want view=%0d disp=%h", e.name, bus.view, disp_all, e.v, e.d);
        end
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_enable();
        test_auto();
        test_latch_live();
        test_step_expiry();
        test_enable_drop();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
